sram_ctrl: RTL and testbench

- Synchronous initiator for the team's asynchronous 16-bit SRAM interface.
- Active-low output-enable and write-enable strobes, 16-bit address, shared bidirectional data bus.
- Converts single-beat user read/write requests (valid/ready) into correctly sequenced strobe cycles and returns read data with a one-cycle response pulse.
- Sits between buffer/UART control logic and the SRAM (or the d_mem model in simulation).

---
 rtl/sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous initiator for an asynchronous 16-bit SRAM.
// Turns single-beat valid/ready requests into setup/strobe/hold sequences
// on active-low mem_oe/mem_we with a shared tri-state data bus.
// Optional write readback-verify is built when SRAM_CTRL_VERIFY_EN is defined.
module sram_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              err_flag,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  logic [DATA_W-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_SETUP,
        RD_PULSE,
        RD_END
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nx;
    logic [DATA_W-1:0] wdata_q;
    logic              drv;
    logic              accept;
    logic              capture;
    logic              vfy;

    assign accept  = (state == IDLE) && req_valid;
    assign capture = (state == RD_PULSE) && (cnt == 8'd0);

    assign mem_data = drv ? wdata_q : {DATA_W{1'bz}};

    // State register and pulse-width down-counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state sequencing of the strobe cycles
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = req_we ? WR_SETUP : RD_SETUP;
                end
            end
            WR_SETUP: begin
                state_nx = WR_PULSE;
                cnt_nx   = 8'(WE_CYCLES - 1);
            end
            WR_PULSE: begin
                if (cnt == 8'd0) begin
                    state_nx = WR_HOLD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            WR_HOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
                state_nx = RD_SETUP;
`else
                state_nx = IDLE;
`endif
            end
            RD_SETUP: begin
                state_nx = RD_PULSE;
                cnt_nx   = 8'(RD_CYCLES - 1);
            end
            RD_PULSE: begin
                if (cnt == 8'd0) begin
                    state_nx = RD_END;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            RD_END: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Strobes and handshakes registered from the next state so they are glitch-free
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_oe    <= 1'b1;
            mem_we    <= 1'b1;
            drv       <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            mem_oe    <= (state_nx != RD_PULSE);
            mem_we    <= (state_nx != WR_PULSE);
            drv       <= (state_nx == WR_SETUP) || (state_nx == WR_PULSE) ||
                         (state_nx == WR_HOLD);
            req_ready <= (state_nx == IDLE);
            rsp_valid <= (state_nx == RD_END) && !vfy;
        end
    end

    // Request latch and read-data capture at the last edge of the oe pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr  <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                mem_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (capture && !vfy) begin
                rsp_rdata <= mem_data;
            end
        end
    end

`ifdef SRAM_CTRL_VERIFY_EN
    logic err_q;

    // Readback-verify: mark the internal read and flag a sticky data mismatch
    always_ff @(posedge clk) begin
        if (!reset) begin
            vfy   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (state == WR_HOLD) begin
                vfy <= 1'b1;
            end else if (state == RD_END) begin
                vfy <= 1'b0;
            end
            if (capture && vfy && (mem_data != wdata_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_flag = err_q;
`else
    assign vfy      = 1'b0;
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with an async SRAM model.
// Reads push expected data/latency into a queue; a monitor pops on rsp_valid.
// Builds in both configurations (SRAM_CTRL_VERIFY_EN defined or not).
module tb_sram_ctrl;

    localparam int WE = 2;
    localparam int RD = 2;
`ifdef SRAM_CTRL_VERIFY_EN
    localparam int WR_OCC = WE + RD + 4;
`else
    localparam int WR_OCC = WE + 2;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        err_flag;
    logic        mem_oe;
    logic        mem_we;
    logic [15:0] mem_addr;
    wire  [15:0] mem_data;

    sram_ctrl #(
        .ADDR_W(16),
        .DATA_W(16),
        .WE_CYCLES(WE),
        .RD_CYCLES(RD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .err_flag(err_flag),
        .mem_oe(mem_oe),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM model: write commits on the rising edge of mem_we
    logic [15:0] mem [0:65535];
    logic        wr_armed = 1'b0;
    logic        corrupt  = 1'b0;
    logic [15:0] rd_val;

    assign rd_val   = mem[mem_addr] ^ ((corrupt && mem_addr == 16'h0030) ? 16'h0001 : 16'h0000);
    assign mem_data = mem_oe ? 16'hzzzz : rd_val;

    always @(negedge mem_we) if (reset) wr_armed = 1'b1;
    always @(posedge mem_we) begin
        if (wr_armed) begin
            mem[mem_addr] = mem_data;
            wr_armed = 1'b0;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [15:0] data;
        int          acc;
    } exp_t;
    exp_t sb_q[$];
    logic started = 1'b0;

    // Monitor: compare every response against the oldest expected read
    always @(negedge clk) begin
        if (started && reset && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_data", rsp_rdata, e.data);
                check("rsp_latency", cyc - e.acc, RD + 2);
            end
        end
    end

    // Bus invariants sampled every cycle
    always @(negedge clk) begin
        if (started && reset) begin
            check("inv_oe_we", !mem_oe && !mem_we, 0);
            check("inv_drv_oe", !mem_oe && dut.drv, 0);
        end
    end

    // Issue one request at a negedge; returns at the first negedge after accept
    task automatic start_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                             output int acc);
        check("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        acc       = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~a;
        req_wdata = ~d;
    endtask

    // Write with cycle-by-cycle strobe/bus waveform check (k = cycles after accept)
    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        int acc;
        start_req(1'b1, a, d, acc);
        for (int k = 1; k <= WR_OCC + 1; k++) begin
            if (k > 1) @(negedge clk);
            check("wr_we", mem_we, (k >= 2 && k <= WE + 1) ? 0 : 1);
            check("wr_drv", dut.drv, (k <= WE + 2) ? 1 : 0);
`ifdef SRAM_CTRL_VERIFY_EN
            check("wr_oe", mem_oe, (k >= WE + 4 && k <= WE + RD + 3) ? 0 : 1);
`else
            check("wr_oe", mem_oe, 1);
`endif
            check("wr_ready", req_ready, (k == WR_OCC + 1) ? 1 : 0);
            if (k <= WR_OCC) check("wr_addr", mem_addr, a);
            if (k <= WE + 2) check("wr_data", mem_data, d);
        end
    endtask

    // Read: expected response goes to the scoreboard; strobes checked inline
    task automatic do_read(input logic [15:0] a, input logic [15:0] d);
        int   acc;
        exp_t e;
        start_req(1'b0, a, 16'h0000, acc);
        e.data = d;
        e.acc  = acc;
        sb_q.push_back(e);
        for (int k = 1; k <= RD + 3; k++) begin
            if (k > 1) @(negedge clk);
            check("rd_oe", mem_oe, (k >= 2 && k <= RD + 1) ? 0 : 1);
            check("rd_we", mem_we, 1);
            check("rd_drv", dut.drv, 0);
            check("rd_ready", req_ready, (k == RD + 3) ? 1 : 0);
            if (k <= RD + 2) check("rd_addr", mem_addr, a);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;

        // Reset held for three clocks, then released
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        started = 1'b1;
        check("rst_oe", mem_oe, 1);
        check("rst_we", mem_we, 1);
        check("rst_drv", dut.drv, 0);
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_err", err_flag, 0);

        // Basic write then read back
        do_write(16'h0010, 16'hBEEF);
        do_read(16'h0010, 16'hBEEF);

        // Top address, back-to-back write/read, untouched location
        do_write(16'hFFFF, 16'h1234);
        do_read(16'hFFFF, 16'h1234);
        do_read(16'h0000, 16'h0000);
        do_read(16'h0010, 16'hBEEF);

        // Reset during the write pulse
        start_req(1'b1, 16'h0020, 16'h5555, acc);
        @(negedge clk);
        check("abort_we_low", mem_we, 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_we", mem_we, 1);
        check("abort_drv", dut.drv, 0);
        check("abort_ready", req_ready, 1);
        check("abort_oe", mem_oe, 1);
        check("abort_rdata", rsp_rdata, 0);
        check("abort_addr", mem_addr, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle_ready", req_ready, 1);

`ifdef SRAM_CTRL_VERIFY_EN
        // Readback-verify: good write, corrupted write, sticky flag, reset clear
        do_write(16'h0040, 16'h1111);
        check("vfy_err_good", err_flag, 0);
        corrupt = 1'b1;
        do_write(16'h0030, 16'hA5A5);
        check("vfy_err_set", err_flag, 1);
        do_write(16'h0041, 16'h2222);
        check("vfy_err_sticky", err_flag, 1);
        check("vfy_rdata_kept", rsp_rdata, 0);
        corrupt = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("vfy_err_cleared", err_flag, 0);
        do_read(16'h0041, 16'h2222);
`else
        check("err_tied_low", err_flag, 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
